// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/data requesters, the shared memory port and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage, with access timeout.
// Optional IF anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1 = data side owns the port
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              bus_err_q, bus_err_d;
  logic              sel_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  logic [STV_W-1:0]  starve_q, starve_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = if_ready_q;
    d_ready_d   = d_ready_q;
    bus_err_d   = bus_err_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
    // After STARVE_LIMIT data wins over a waiting IF, IF takes the next tie.
    sel_d       = bus.d_req && !(bus.if_req && (starve_q == STV_W'(STARVE_LIMIT)));
`else
    sel_d       = bus.d_req;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.d_req || bus.if_req) begin
          owner_d_d = sel_d;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = ACCESS;
          if (sel_d) begin
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_wstrb_d = bus.d_wstrb;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
`ifdef ARB_STARVE_GUARD_EN
          if (!sel_d) begin
            starve_d = '0;
          end else if (bus.if_req) begin
            starve_d = starve_q + STV_W'(1);
          end
`endif
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (owner_d_q) begin
            d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
          if (owner_d_q) begin
            d_rdata_d = '0;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        bus_err_d  = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: expected completions queued at request time,
// popped and compared when a ready pulse appears.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;
  localparam int unsigned SL = 4;

  logic clock = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] last_if_rdata = '0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_wstrb   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    bit got_rdy;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.bus_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.bus_err});
    end
    n_checks++;
    if ((bus.if_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata | DW'(bus.mem_wstrb)) !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h/%h/%h expected all 0",
               bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    reset = 1'b0;
    tick();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h100;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL reset_pre_access: got req=%b addr=%h expected req=1 addr=00000100",
               bus.mem_req, bus.mem_addr);
    end
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_drop: got mem_req=%b expected 0", bus.mem_req);
    end
    bus.d_req = 1'b0;
    got_rdy = 1'b0;
    repeat (3) begin
      tick();
      if (bus.d_ready !== 1'b0) got_rdy = 1'b1;
    end
    reset = 1'b0;
    repeat (4) begin
      tick();
      if (bus.d_ready !== 1'b0 || bus.mem_req !== 1'b0) got_rdy = 1'b1;
    end
    n_checks++;
    if (got_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_ready: got stray activity=%b expected 0", got_rdy);
    end
    // Back in IDLE: a fresh IF request must be granted one cycle later.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h44 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_grant: got req=%b addr=%h we=%b expected 1/00000044/0",
               bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_1234;
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    last_if_rdata = 32'h0000_1234;
    n_checks++;
    if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL reset_idle_done: got rdy=%b rdata=%h expected 1/00001234",
               bus.if_ready, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_if_read();
    exp_t e;
    sb.push_back('{is_d: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0});
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL if_read_issue: got req=%b addr=%h we=%b strb=%h expected 1/00000040/0/0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wstrb);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.if_ready !== 1'b1 || bus.d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_ready: got req=%b if_rdy=%b d_rdy=%b expected 0/1/0",
               bus.mem_req, bus.if_ready, bus.d_ready);
    end
    e = sb.pop_front();
    last_if_rdata = e.rdata;
    n_checks++;
    if (bus.if_rdata !== e.rdata || bus.bus_err !== e.err) begin
      n_fail++;
      $display("FAIL if_read_data: got rdata=%h err=%b expected %h/%b",
               bus.if_rdata, bus.bus_err, e.rdata, e.err);
    end
    bus.if_req = 1'b0;
    tick();
    n_checks++;
    if (bus.if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_pulse: got if_ready=%b expected 0", bus.if_ready);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b0});
    sb.push_back('{is_d: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'h1234_5678;
    bus.d_wstrb = 4'hF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    tick();
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL prio_data_first: got we=%b addr=%h wdata=%h strb=%h expected 1/00000200/12345678/f",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hAAAA_5555;
    tick();
    bus.mem_ack = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (bus.d_ready !== 1'b1 || bus.if_ready !== 1'b0 || bus.d_rdata !== e.rdata || bus.bus_err !== e.err) begin
      n_fail++;
      $display("FAIL prio_write_done: got d_rdy=%b if_rdy=%b d_rdata=%h err=%b expected 1/0/%h/%b",
               bus.d_ready, bus.if_ready, bus.d_rdata, bus.bus_err, e.rdata, e.err);
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_gap: got req=%b if_rdy=%b expected 0/0", bus.mem_req, bus.if_ready);
    end
    tick();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_if_second: got req=%b addr=%h we=%b expected 1/00000080/0",
               bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    bus.mem_ack = 1'b0;
    e = sb.pop_front();
    last_if_rdata = e.rdata;
    n_checks++;
    if (bus.if_ready !== 1'b1 || bus.if_rdata !== e.rdata || bus.d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL prio_if_done: got rdy=%b rdata=%h d_rdata=%h expected 1/%h/00000000",
               bus.if_ready, bus.if_rdata, bus.d_rdata, e.rdata);
    end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    exp_t e;
    int   hi = 0;
    bit   early = 1'b0;
    sb.push_back('{is_d: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0});
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h300;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h300) hi++;
      if (bus.d_ready !== 1'b0) early = 1'b1;
      if (i == 5) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_0001;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    n_checks++;
    if (hi != 6 || early) begin
      n_fail++;
      $display("FAIL wait_hold: got stable-req cycles=%0d early_ready=%b expected 6/0", hi, early);
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.d_ready !== 1'b1 || bus.d_rdata !== e.rdata || bus.bus_err !== e.err) begin
      n_fail++;
      $display("FAIL wait_done: got req=%b rdy=%b rdata=%h err=%b expected 0/1/%h/%b",
               bus.mem_req, bus.d_ready, bus.d_rdata, bus.bus_err, e.rdata, e.err);
    end
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   hi = 0;
    sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b1});
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h400;
    tick();
    while (bus.mem_req === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    n_checks++;
    if (hi != int'(TO)) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d access cycles expected %0d", hi, TO);
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.d_ready !== 1'b1 || bus.bus_err !== e.err || bus.d_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL timeout_abort: got rdy=%b err=%b rdata=%h expected 1/%b/%h",
               bus.d_ready, bus.bus_err, bus.d_rdata, e.err, e.rdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    bus.d_req     = 1'b0;
    tick();
    n_checks++;
    if (bus.d_ready !== 1'b0 || bus.bus_err !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: got rdy=%b err=%b req=%b expected 0/0/0",
               bus.d_ready, bus.bus_err, bus.mem_req);
    end
    tick();
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.d_rdata !== 32'h0 || bus.mem_req !== 1'b0 || bus.d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_late_ack: got rdata=%h req=%b rdy=%b expected 00000000/0/0",
               bus.d_rdata, bus.mem_req, bus.d_ready);
    end
    tick();
  endtask

  task automatic test_starve();
    exp_t          e;
    bit            got_d;
    bit            granted;
    logic [DW-1:0] rd;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      sb.push_back('{is_d: (k != int'(SL)), rdata: 32'h5000_0000 + DW'(k), err: 1'b0});
`else
      sb.push_back('{is_d: 1'b1, rdata: 32'h5000_0000 + DW'(k), err: 1'b0});
`endif
    end
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h500;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    for (int k = 0; k < 6; k++) begin
      granted = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bus.mem_req === 1'b1) begin
          granted = 1'b1;
          break;
        end
      end
      e = sb.pop_front();
      n_checks++;
      if (!granted) begin
        n_fail++;
        $display("FAIL starve_grant_%0d: got no mem_req within 10 cycles expected a grant", k);
        break;
      end
      got_d = (bus.mem_addr === 32'h500);
      if (got_d !== e.is_d || (!got_d && bus.mem_addr !== 32'h600)) begin
        n_fail++;
        $display("FAIL starve_order_%0d: got addr=%h expected owner %s", k, bus.mem_addr, e.is_d ? "D" : "I");
      end
      rd = 32'h5000_0000 + DW'(k);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd;
      tick();
      bus.mem_ack = 1'b0;
      if (!e.is_d) last_if_rdata = e.rdata;
      n_checks++;
      if (e.is_d ? (bus.d_ready !== 1'b1 || bus.if_ready !== 1'b0 || bus.d_rdata !== e.rdata)
                 : (bus.if_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.if_rdata !== e.rdata)) begin
        n_fail++;
        $display("FAIL starve_done_%0d: got d_rdy=%b if_rdy=%b d_rdata=%h if_rdata=%h expected owner %s rdata %h",
                 k, bus.d_ready, bus.if_ready, bus.d_rdata, bus.if_rdata, e.is_d ? "D" : "I", e.rdata);
      end
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.if_rdata !== last_if_rdata) begin
      n_fail++;
      $display("FAIL starve_if_hold: got if_rdata=%h expected %h", bus.if_rdata, last_if_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_wait_states();
    test_timeout();
    test_starve();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single shared memory port between the instruction-fetch requester (IF) and the data-memory requester (MEM stage) of the pipelined RISC-V core. Owns a small FSM that registers the winning request, drives the memory-side handshake, returns read data and a one-cycle ready pulse to the winner, and aborts hung accesses after a bounded wait. The pipeline's hazard logic stalls each stage while that stage's request is pending and its ready is low.

Parameters:
ADDR_W, 32, address width of both requesters and memory port
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 16, max ACCESS cycles without mem_ack before abort (>=2)
STARVE_LIMIT, 4, consecutive data grants that force an IF grant (optional feature only)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  IF access request, held until if_ready
if_addr  input  ADDR_W  IF word address, stable while if_req
if_rdata  output  DATA_W  IF read data, valid with if_ready
if_ready  output  1  one-cycle completion pulse to IF
d_req  input  1  data access request, held until d_ready
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_wstrb  input  DATA_W/8  byte write strobes
d_rdata  output  DATA_W  data read data, valid with d_ready
d_ready  output  1  one-cycle completion pulse to data side
mem_req  output  1  memory request, held until mem_ack or abort
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wstrb  output  DATA_W/8  memory byte strobes
mem_ack  input  1  memory completion; mem_rdata valid same cycle
mem_rdata  input  DATA_W  memory read data
bus_err  output  1  pulses with ready when access was aborted by timeout

Behaviour:
- Reset (async): state IDLE; all outputs 0; owner, wait counter, starvation counter cleared. Reset mid-access drops mem_req immediately; no ready pulse afterwards.
- All outputs are registered.
- States: IDLE, ACCESS, DONE.
- IDLE: if d_req -> owner=D; else if if_req -> owner=I; latch addr/we/wdata/wstrb (IF: we=0, wstrb=0) into mem_* regs, mem_req<=1, wait counter<=0, -> ACCESS. No request: stay.
- Simultaneous d_req and if_req in IDLE: data wins.
- ACCESS: mem_req=1, mem_* stable. On mem_ack: capture mem_rdata into owner's rdata (write: rdata<=0), mem_req<=0, owner's ready<=1, -> DONE. Without ack: counter++; when counter reaches TIMEOUT-1 without ack: mem_req<=0, rdata<=0, ready<=1, bus_err<=1, -> DONE.
- DONE: ready/bus_err high exactly this cycle; no arbitration (requester still holds req this cycle); -> IDLE, ready/bus_err<=0.
- Min latency: req seen cycle 0, mem_req cycle 1, ack cycle 1, ready cycle 2. Next grant earliest cycle 3.
- Non-owner's ready never pulses; its rdata holds last value.
- Requester dropping req while in ACCESS is illegal; arbiter completes access anyway.
- mem_ack outside ACCESS ignored.

Optional Feature:
ARB_STARVE_GUARD_EN: when defined, a counter tracks consecutive data grants made while if_req was also high; at STARVE_LIMIT, next IDLE arbitration with both requesting grants IF and clears the counter (also cleared on any IF grant). Undefined: strict data priority, no counter, IF may starve.

Test Plan:
- Reset mid-ACCESS (d read to 0x100 pending) -> mem_req 0 same cycle as reset, d_ready never pulses, state IDLE after release.
- IF read 0x40, mem_ack cycle 1 with 0xDEADBEEF -> mem_req high cycle 1 only, if_ready and if_rdata=0xDEADBEEF at cycle 2, bus_err 0.
- d_req write 0x200, wdata 0x12345678, wstrb 0xF, simultaneous if_req -> data granted first (mem_we=1, mem_addr=0x200), d_ready pulse, then IF granted at cycle 3.
- Data read with mem_ack after 5 wait cycles -> mem_req held 6 cycles, mem_addr stable, d_ready one cycle after ack.
- Data read, no mem_ack, TIMEOUT=16 -> mem_req dropped after 16 ACCESS cycles, d_ready=1, bus_err=1, d_rdata=0 same cycle, late mem_ack ignored.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, both req continuously -> grant order D,D,D,D,I,D...; macro undefined -> IF never granted while d_req held.
